// File: rtl/manchester_deserializer.sv
// Manchester line decoder with preamble/sync-word alignment, AXI-Stream byte output.
// Keeps one byte in reserve so the last byte of a frame can be flagged with tlast.
module manchester_deserializer #(
  parameter int         HALF_CYCLES = 4,
  parameter logic [7:0] SYNC_WORD   = 8'hD5
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       serial_in,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       locked,
  output logic       overflow
);

  localparam int ACCEPT_CYCLES = (3 * HALF_CYCLES) / 2;
  localparam int LOSS_CYCLES   = 3 * HALF_CYCLES;
  localparam int TW            = $clog2(LOSS_CYCLES + 1);
  localparam logic [TW-1:0] ACCEPT_T = TW'(ACCEPT_CYCLES);
  localparam logic [TW-1:0] LOSS_T   = TW'(LOSS_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    DATA  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    sync_reg;
  logic [TW-1:0] timer_reg, timer_next;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic          byte_done_reg, byte_done_next;
  logic [7:0]    byte_reg, byte_next;
  logic [7:0]    hold_reg, hold_next;
  logic          hold_valid_reg, hold_valid_next;
  logic [7:0]    tdata_reg, tdata_next;
  logic          tvalid_reg, tvalid_next;
  logic          tlast_reg, tlast_next;
  logic          locked_reg;
  logic          overflow_reg, overflow_next;

  logic       transition;
  logic       mid_bit;
  logic       lock_lost;
  logic       slot_free;
  logic [7:0] shifted;

  // sync_reg[1] is the synchronized line, sync_reg[2] its previous value
  assign transition = sync_reg[1] ^ sync_reg[2];
  assign mid_bit    = transition && (timer_reg >= ACCEPT_T);
  assign lock_lost  = (timer_reg == LOSS_T);
  assign slot_free  = !tvalid_reg || m_axis_tready;
  assign shifted    = {shift_reg[6:0], sync_reg[1]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], serial_in};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      byte_done_reg  <= 1'b0;
      byte_reg       <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      tdata_reg      <= '0;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
      locked_reg     <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      byte_done_reg  <= byte_done_next;
      byte_reg       <= byte_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      tdata_reg      <= tdata_next;
      tvalid_reg     <= tvalid_next;
      tlast_reg      <= tlast_next;
      locked_reg     <= (state_reg == HUNT) || (state_reg == DATA);
      overflow_reg   <= overflow_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = lock_lost ? timer_reg : timer_reg + 1'b1;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    byte_done_next  = 1'b0;
    byte_next       = byte_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    tdata_next      = tdata_reg;
    tvalid_next     = tvalid_reg;
    tlast_next      = tlast_reg;
    overflow_next   = 1'b0;

    if (tvalid_reg && m_axis_tready) begin
      tvalid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        // No timing reference yet, so the first edge is taken as a mid-bit
        if (transition) begin
          timer_next = '0;
          shift_next = shifted;
          state_next = HUNT;
        end
      end
      HUNT: begin
        if (mid_bit) begin
          timer_next = '0;
          shift_next = shifted;
          if (shifted == SYNC_WORD) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end else if (lock_lost) begin
          state_next = IDLE;
          shift_next = '0;
        end
      end
      DATA: begin
        if (mid_bit) begin
          timer_next   = '0;
          shift_next   = shifted;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) begin
            byte_done_next = 1'b1;
            byte_next      = shifted;
          end
        end else if (lock_lost) begin
          state_next   = hold_valid_reg ? FLUSH : IDLE;
          shift_next   = '0;
          bit_cnt_next = '0;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          tdata_next      = hold_reg;
          tlast_next      = 1'b1;
          tvalid_next     = 1'b1;
          hold_next       = '0;
          hold_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A finished byte waits in hold until the next one proves it is not the last
    if (byte_done_reg) begin
      if (!hold_valid_reg) begin
        hold_next       = byte_reg;
        hold_valid_next = 1'b1;
      end else if (slot_free) begin
        tdata_next  = hold_reg;
        tlast_next  = 1'b0;
        tvalid_next = 1'b1;
        hold_next   = byte_reg;
      end else begin
        overflow_next = 1'b1;
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign locked        = locked_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_manchester_deserializer.sv
// Directed + randomized bench: frames are Manchester-encoded here and the decoded
// stream is compared with a bit-level sync search over the transmitted frame.
module tb_manchester_deserializer;

  localparam int         HC   = 4;
  localparam logic [7:0] SYNC = 8'hD5;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       serial_in;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       locked;
  logic       overflow;

  manchester_deserializer #(.HALF_CYCLES(HC), .SYNC_WORD(SYNC)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .serial_in    (serial_in),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .locked       (locked),
    .overflow     (overflow)
  );

  initial forever #5 aclk = ~aclk;

  int cyc = 0;
  initial forever begin
    @(posedge aclk);
    cyc = cyc + 1;
  end

  int pass_cnt = 0;
  int fail_cnt = 0;
  int check_cnt = 0;
  bit rand_ready = 1'b0;

  // Monitor: sampled late in each cycle, just before the next active edge
  logic [8:0] xfer_q[$];
  int         rise_q[$];
  int         fall_q[$];
  int         ovf_cnt = 0;
  int         lock_rises = 0;
  int         stab_viol = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_locked = 1'b0, prev_rstn = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  initial begin
    forever begin
      @(posedge aclk);
      #7;
      if (m_axis_tvalid && m_axis_tready) xfer_q.push_back({m_axis_tlast, m_axis_tdata});
      if (overflow) ovf_cnt++;
      if (m_axis_tvalid && !prev_valid) rise_q.push_back(cyc);
      if (locked && !prev_locked) lock_rises++;
      if (!locked && prev_locked) fall_q.push_back(cyc);
      if (aresetn && prev_rstn && prev_valid && !prev_ready &&
          (!m_axis_tvalid || m_axis_tdata != prev_data || m_axis_tlast != prev_last))
        stab_viol++;
      prev_valid  = m_axis_tvalid;
      prev_ready  = m_axis_tready;
      prev_locked = locked;
      prev_rstn   = aresetn;
      prev_data   = m_axis_tdata;
      prev_last   = m_axis_tlast;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  // Line encoder: levels per aclk cycle, with optional per-edge jitter
  logic line_q[$];
  int   mid_q[$];
  int   prev_off;
  int   play_start;

  task automatic push_level(input logic lvl, input int n);
    repeat (n) line_q.push_back(lvl);
  endtask

  task automatic add_byte(input logic [7:0] b, input bit jit);
    for (int i = 7; i >= 0; i--) begin
      int om;
      int ob;
      om = jit ? int'($urandom_range(0, 1)) : 0;
      ob = jit ? int'($urandom_range(0, 2)) - 1 : 0;
      push_level(~b[i], HC - prev_off + om);
      mid_q.push_back(line_q.size());
      push_level(b[i], HC - om + ob);
      prev_off = ob;
    end
  endtask

  task automatic build(input logic [7:0] fr[$], input bit jit);
    line_q.delete();
    mid_q.delete();
    prev_off = 0;
    push_level(1'b1, 4);
    foreach (fr[k]) add_byte(fr[k], jit);
    push_level(1'b1, 44 + HC);
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) play_start = cyc;
      serial_in = line_q[i];
    end
  endtask

  // Reference: find the sync word anywhere in the bit stream, then take whole bytes
  logic [8:0] exp_q[$];
  int         exp_ovf;

  task automatic model(input logic [7:0] fr[$], input bit stalled);
    logic       bits[$];
    logic [7:0] w;
    logic [7:0] v;
    logic [7:0] pay[$];
    int         start;
    int         n_out;
    exp_q.delete();
    foreach (fr[k]) for (int i = 7; i >= 0; i--) bits.push_back(fr[k][i]);
    w = '0;
    start = -1;
    for (int i = 0; i < bits.size(); i++) begin
      w = {w[6:0], bits[i]};
      if (w == SYNC) begin
        start = i + 1;
        break;
      end
    end
    if (start >= 0) begin
      for (int j = start; j + 8 <= bits.size(); j += 8) begin
        for (int k = 0; k < 8; k++) v = {v[6:0], bits[j+k]};
        pay.push_back(v);
      end
    end
    n_out   = stalled ? ((pay.size() < 2) ? pay.size() : 2) : pay.size();
    exp_ovf = pay.size() - n_out;
    for (int k = 0; k < n_out; k++) exp_q.push_back({(k == n_out - 1), pay[k]});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((m_axis_tvalid || locked) && n < 400) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, (n < 400), 1);
    repeat (3) tick();
  endtask

  task automatic compare(input string name, input int base);
    int got;
    got = xfer_q.size() - base;
    check({name, "_count"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      check({name, "_data"}, xfer_q[base+i][7:0], exp_q[i][7:0]);
      check({name, "_last"}, xfer_q[base+i][8], exp_q[i][8]);
    end
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input bit jit, input string name);
    int xb, ob, lb, sb;
    xb = xfer_q.size();
    ob = ovf_cnt;
    lb = lock_rises;
    sb = stab_viol;
    model(fr, 1'b0);
    build(fr, jit);
    play(line_q.size());
    drain(name);
    compare(name, xb);
    check({name, "_overflow"}, ovf_cnt - ob, 0);
    check({name, "_lock_episodes"}, lock_rises - lb, 1);
    check({name, "_hold_stable"}, stab_viol - sb, 0);
  endtask

  initial begin
    logic [7:0] fr[$];
    int rb, fb, d, xb, ob, n;
    aresetn       = 1'b0;
    serial_in     = 1'b1;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_locked", locked, 0);
    check("rst_overflow", overflow, 0);
    aresetn = 1'b1;
    repeat (20) tick();

    // Basic frame: latency of first valid and lock release after the last mid-bit
    fr = '{8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03};
    rb = rise_q.size();
    fb = fall_q.size();
    run_frame(fr, 1'b0, "basic");
    d = (rise_q.size() > rb) ? rise_q[rb] - (play_start + mid_q[39]) : -1;
    check("basic_latency", d, 4);
    d = (fall_q.size() > fb) ? fall_q[fb] - (play_start + mid_q[mid_q.size()-1]) : -1;
    check("basic_lock_fall_window", (d >= 12 && d <= 18), 1);

    // No sync word: locks briefly, nothing delivered
    fr = '{8'h55, 8'h55, 8'hA5, 8'hA5};
    run_frame(fr, 1'b0, "nosync");
    check("nosync_locked_end", locked, 0);

    // Single-byte frame
    fr = '{8'h55, 8'h55, 8'hD5, 8'h7E};
    run_frame(fr, 1'b0, "single");

    // Stalled sink: two bytes kept, the rest dropped with overflow pulses
    fr = '{8'h55, 8'h55, 8'hD5};
    repeat (8) fr.push_back(8'($urandom_range(0, 255)));
    m_axis_tready = 1'b0;
    xb = xfer_q.size();
    ob = ovf_cnt;
    model(fr, 1'b1);
    build(fr, 1'b0);
    play(line_q.size());
    check("stall_tvalid", m_axis_tvalid, 1);
    check("stall_tdata", m_axis_tdata, exp_q[0][7:0]);
    check("stall_tlast", m_axis_tlast, 0);
    check("stall_overflow", ovf_cnt - ob, exp_ovf);
    m_axis_tready = 1'b1;
    drain("stall");
    compare("stall", xb);
    check("stall_hold_stable", stab_viol, 0);

    // Reset in the middle of a payload with bytes pending
    fr = '{8'h55, 8'h55, 8'hD5};
    repeat (4) fr.push_back(8'($urandom_range(0, 255)));
    m_axis_tready = 1'b0;
    build(fr, 1'b0);
    play(mid_q[43] + 1);
    check("midrst_pre_tvalid", m_axis_tvalid, 1);
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tdata", m_axis_tdata, 0);
    check("midrst_tlast", m_axis_tlast, 0);
    check("midrst_locked", locked, 0);
    check("midrst_overflow", overflow, 0);
    repeat (3) tick();
    aresetn       = 1'b1;
    serial_in     = 1'b1;
    m_axis_tready = 1'b1;
    xb = xfer_q.size();
    repeat (60) tick();
    check("midrst_no_stale", xfer_q.size() - xb, 0);
    fr = '{8'h55, 8'h55, 8'hD5, 8'hAA, 8'hBB};
    run_frame(fr, 1'b0, "after_rst");

    // Jittered line, random payload, random backpressure
    rand_ready = 1'b1;
    fr = '{8'h55, 8'h55, 8'hD5};
    repeat (6) fr.push_back(8'($urandom_range(0, 255)));
    run_frame(fr, 1'b1, "jitter");

    for (int f = 0; f < 3; f++) begin
      fr = '{8'h55, 8'h55, 8'hD5};
      n = $urandom_range(1, 4);
      repeat (n) fr.push_back(8'($urandom_range(0, 255)));
      run_frame(fr, 1'($urandom_range(0, 1)), "random");
    end
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
